// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Two-requester round-robin arbiter and sequencer in front of a single-port,
//   word-organised data memory with a fixed read latency. One access is granted
//   per cycle at most. Writes complete at the grant edge. A read keeps the block
//   busy until the data returns. The data is then registered and presented with
//   a one-cycle rvalid pulse to the port that issued the read.
//
// Handshake (both request ports):
//   A requester raises mN_req with all mN_* fields stable and holds them until
//   it sees mN_gnt=1 in the same cycle. The request is consumed at the rising
//   edge that ends the grant cycle. Read data comes back later as a one-cycle
//   mN_rvalid pulse, and mN_rdata is meaningful only while that pulse is high.
//   No grant is issued while a read is outstanding (busy=1).
//
// Parameters:
//   MEM_LATENCY   cycles from an accepted memory read to mem_rdata valid (1..4)
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   m0_*                          port 0 (load/store unit): req/we/addr/wdata/be
//                                 in, gnt/rvalid/rdata out
//   m1_*                          port 1 (secondary master), same shape as m0_*
//   mem_req/we/addr/wdata/be      memory request, driven from the granted port
//   mem_rdata                     memory read data, valid MEM_LATENCY cycles
//                                 after the read's mem_req cycle
//   busy                          high while a read is outstanding (WAIT)
//   dbg_state_o                   current FSM state (0=IDLE, 1=WAIT, 2=RESP)
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,

  output logic        busy,
  output logic [1:0]  dbg_state_o
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
    $error("dmem_port_arbiter: MEM_LATENCY must be in 1..4");
  end

  // Counter start value: the counter reaches 0 in the cycle mem_rdata is valid.
  localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;        // port that issued the outstanding read
  logic        last_gnt_q, last_gnt_d;  // port granted most recently
  logic [31:0] rdata_q, rdata_d;

  logic arb_en;
  logic gnt0, gnt1;
  logic any_gnt;
  logic gnt_we;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are combinational from the requests and are forced low
  // during reset and while a read is outstanding. On a conflict the port that
  // was not granted last wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    arb_en  = rst_n && (state_q != S_WAIT);
    gnt0    = arb_en && m0_req && (!m1_req || last_gnt_q);
    gnt1    = arb_en && m1_req && (!m0_req || !last_gnt_q);
    any_gnt = gnt0 || gnt1;
    gnt_we  = gnt1 ? m1_we : m0_we;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    last_gnt_d = last_gnt_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      // RESP arbitrates exactly like IDLE, so a read can be granted in the same
      // cycle the previous read's rvalid is shown.
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (any_gnt) begin
          last_gnt_d = gnt1;
          if (!gnt_we) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
            owner_d = gnt1;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_gnt    = gnt0;
    m1_gnt    = gnt1;
    mem_req   = any_gnt;
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_be    = 4'b0000;

    if (gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_be    = m0_we ? m0_be : 4'b0000;
    end else if (gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_be    = m1_we ? m1_be : 4'b0000;
    end

    m0_rvalid   = rst_n && (state_q == S_RESP) && !owner_q;
    m1_rvalid   = rst_n && (state_q == S_RESP) &&  owner_q;
    m0_rdata    = rdata_q;
    m1_rdata    = rdata_q;
    busy        = rst_n && (state_q == S_WAIT);
    dbg_state_o = state_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Three arbiters with MEM_LATENCY 1, 2 and 3 share one set of request inputs;
// each has its own memory model that returns data only in the exact cycle
// MEM_LATENCY after a read strobe. Each scenario selects the instance whose
// latency it exercises and resets all instances first.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared request inputs ----------------
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_be = '0;

  // ---------------- per-instance outputs ----------------
  logic        m0_gnt [3], m1_gnt [3], m0_rvalid [3], m1_rvalid [3];
  logic [31:0] m0_rdata [3], m1_rdata [3];
  logic        mem_req [3], mem_we [3], busy [3];
  logic [31:0] mem_addr [3], mem_wdata [3], mem_rdata [3];
  logic [3:0]  mem_be [3];
  logic [1:0]  dbg_state [3];

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEAD_BEEF;
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [31:0] pipe [4];

    dmem_port_arbiter #(.MEM_LATENCY(g + 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .m0_req     (m0_req),
      .m0_we      (m0_we),
      .m0_addr    (m0_addr),
      .m0_wdata   (m0_wdata),
      .m0_be      (m0_be),
      .m0_gnt     (m0_gnt[g]),
      .m0_rvalid  (m0_rvalid[g]),
      .m0_rdata   (m0_rdata[g]),
      .m1_req     (m1_req),
      .m1_we      (m1_we),
      .m1_addr    (m1_addr),
      .m1_wdata   (m1_wdata),
      .m1_be      (m1_be),
      .m1_gnt     (m1_gnt[g]),
      .m1_rvalid  (m1_rvalid[g]),
      .m1_rdata   (m1_rdata[g]),
      .mem_req    (mem_req[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_be     (mem_be[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g]),
      .dbg_state_o(dbg_state[g])
    );

    // Data appears only in the cycle exactly g+1 cycles after the read strobe.
    always @(posedge clk) begin
      pipe[0] <= (mem_req[g] && !mem_we[g]) ? mem_fn(mem_addr[g]) : 32'h0BAD_0BAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata[g] = pipe[g];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int sel = 0;
  logic [32:0] exp_q[$];   // {port, read data}
  logic [67:0] wexp_q[$];  // {addr, be, wdata}

  function automatic logic [140:0] outs(input int g);
    return {m0_gnt[g], m1_gnt[g], m0_rvalid[g], m1_rvalid[g], mem_req[g], mem_we[g],
            busy[g], mem_be[g], mem_addr[g], mem_wdata[g], m0_rdata[g], m1_rdata[g],
            dbg_state[g]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_rvalid[sel] || m1_rvalid[sel]) begin
        logic [32:0] got, e;
        n_cmp++;
        got = {m1_rvalid[sel], m1_rvalid[sel] ? m1_rdata[sel] : m0_rdata[sel]};
        if (m0_rvalid[sel] && m1_rvalid[sel]) begin
          n_bad++;
          $display("FAIL rvalid_both inst=%0d: both rvalid high, required one", sel);
        end else if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rvalid_unexpected inst=%0d: got port%0d data %h, required no response",
                   sel, got[32], got[31:0]);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL read_resp inst=%0d: got port%0d %h, required port%0d %h",
                     sel, got[32], got[31:0], e[32], e[31:0]);
          end
        end
      end
      if (mem_req[sel] && mem_we[sel]) begin
        logic [67:0] wg, we_;
        n_cmp++;
        wg = {mem_addr[sel], mem_be[sel], mem_wdata[sel]};
        if (wexp_q.size() == 0) begin
          n_bad++;
          $display("FAIL write_unexpected inst=%0d: got %h, required no write", sel, wg);
        end else begin
          we_ = wexp_q.pop_front();
          if (wg !== we_) begin
            n_bad++;
            $display("FAIL mem_write inst=%0d: got addr/be/data %h, required %h", sel, wg, we_);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
  endtask

  task automatic drive_m0(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
  endtask

  task automatic drive_m1(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
  endtask

  task automatic do_reset(input int g);
    step();
    drive_idle();
    rst_n = 1'b0;
    exp_q.delete();
    wexp_q.delete();
    sel = g;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0 || wexp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained: %0d reads / %0d writes left, required 0 / 0",
               name, exp_q.size(), wexp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_m0(1'b1, 32'h100, 32'h1, 4'hF);
    drive_m1(1'b0, 32'h200, 32'h2, 4'hF);
    rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      n_cmp++;
      if (outs(g) !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs inst=%0d: got %h, required 0", g, outs(g));
      end
    end
    drive_idle();
  endtask

  task automatic test_single_read();
    do_reset(1);
    step();
    drive_m0(1'b0, 32'h10, 32'h0, 4'hF);
    exp_q.push_back({1'b0, mem_fn(32'h10)});
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt[1], m1_gnt[1], mem_req[1], mem_we[1], mem_be[1], mem_addr[1]} !==
        {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h10}) begin
      n_bad++;
      $display("FAIL single_read_grant: gnt0=%b gnt1=%b req=%b we=%b be=%b addr=%h, required 1 0 1 0 0000 00000010",
               m0_gnt[1], m1_gnt[1], mem_req[1], mem_we[1], mem_be[1], mem_addr[1]);
    end
    step();
    drive_idle();
    for (int c = 1; c <= 4; c++) begin
      logic [2:0] exp_v;
      @(negedge clk);
      exp_v = {(c == 1 || c == 2), (c == 3), 1'b0};
      n_cmp++;
      if ({busy[1], m0_rvalid[1], m1_rvalid[1]} !== exp_v) begin
        n_bad++;
        $display("FAIL single_read_T+%0d: busy/rv0/rv1=%b, required %b",
                 c, {busy[1], m0_rvalid[1], m1_rvalid[1]}, exp_v);
      end
      if (c == 3) begin
        n_cmp++;
        if (m0_rdata[1] !== 32'hDEAD_BEEF) begin
          n_bad++;
          $display("FAIL single_read_data: got %h, required deadbeef", m0_rdata[1]);
        end
      end
      step();
    end
    check_drained("single_read");
  endtask

  task automatic test_contention();
    logic last;
    do_reset(0);
    last = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      logic win;
      drive_m0(1'b1, 32'h100 + 32'(c), 32'h1111_0000 + 32'(c), 4'b1111);
      drive_m1(1'b1, 32'h200 + 32'(c), 32'h2222_0000 + 32'(c), 4'b0101);
      win = ~last;
      last = win;
      if (win) wexp_q.push_back({32'h200 + 32'(c), 4'b0101, 32'h2222_0000 + 32'(c)});
      else     wexp_q.push_back({32'h100 + 32'(c), 4'b1111, 32'h1111_0000 + 32'(c)});
      @(negedge clk);
      n_cmp++;
      if ({m0_gnt[0], m1_gnt[0]} !== {~win, win}) begin
        n_bad++;
        $display("FAIL contention_c%0d: gnt0/gnt1=%b%b, required %b%b",
                 c, m0_gnt[0], m1_gnt[0], ~win, win);
      end
      step();
    end
    drive_idle();
    @(negedge clk);
    check_drained("contention");
  endtask

  task automatic test_back_to_back();
    do_reset(0);
    step();
    for (int c = 0; c < 3; c++) begin
      logic [31:0] d;
      d = $urandom();
      drive_m1(1'b1, 32'(4 * c), d, 4'b0011);
      wexp_q.push_back({32'(4 * c), 4'b0011, d});
      @(negedge clk);
      n_cmp++;
      if ({m1_gnt[0], mem_req[0], mem_we[0], mem_be[0]} !== {3'b111, 4'b0011}) begin
        n_bad++;
        $display("FAIL b2b_write_c%0d: gnt/req/we/be=%b, required 1110011",
                 c, {m1_gnt[0], mem_req[0], mem_we[0], mem_be[0]});
      end
      step();
    end
    drive_idle();
    @(negedge clk);
    n_cmp++;
    if ({mem_req[0], mem_we[0], mem_be[0], mem_addr[0], mem_wdata[0]} !== '0) begin
      n_bad++;
      $display("FAIL b2b_idle_bus: req/we/be=%b addr=%h wdata=%h, required all 0",
               {mem_req[0], mem_we[0], mem_be[0]}, mem_addr[0], mem_wdata[0]);
    end
    check_drained("b2b");
  endtask

  task automatic test_stall_wait();
    do_reset(2);
    step();
    drive_m0(1'b0, 32'h40, 32'h0, 4'h0);
    exp_q.push_back({1'b0, mem_fn(32'h40)});
    @(negedge clk);
    n_cmp++;
    if (m0_gnt[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_first_grant: got %b, required 1", m0_gnt[2]);
    end
    step();
    drive_idle();
    drive_m1(1'b0, 32'h80, 32'h0, 4'hF);
    exp_q.push_back({1'b1, mem_fn(32'h80)});
    for (int c = 1; c <= 8; c++) begin
      logic [3:0] exp_v;
      @(negedge clk);
      // {m1_gnt, busy, m0_rvalid, m1_rvalid}
      exp_v = {(c == 4), (c inside {[1:3], [5:7]}), (c == 4), (c == 8)};
      n_cmp++;
      if ({m1_gnt[2], busy[2], m0_rvalid[2], m1_rvalid[2]} !== exp_v) begin
        n_bad++;
        $display("FAIL stall_T+%0d: gnt1/busy/rv0/rv1=%b, required %b",
                 c, {m1_gnt[2], busy[2], m0_rvalid[2], m1_rvalid[2]}, exp_v);
      end
      step();
      if (c == 4) drive_idle();
    end
    check_drained("stall");
  endtask

  task automatic test_reset_mid_read();
    do_reset(1);
    step();
    drive_m0(1'b0, 32'h20, 32'h0, 4'h0);
    @(negedge clk);
    n_cmp++;
    if (m0_gnt[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_grant: got %b, required 1", m0_gnt[1]);
    end
    step();
    drive_idle();
    drive_m1(1'b1, 32'h300, 32'h5, 4'hF);
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++;
      if (outs(1) !== '0) begin
        n_bad++;
        $display("FAIL midrst_outputs_c%0d: got %h, required 0", c, outs(1));
      end
      step();
    end
    drive_idle();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({m0_rvalid[1], m1_rvalid[1], busy[1]} !== 3'b000) begin
        n_bad++;
        $display("FAIL midrst_quiet_c%0d: rv0/rv1/busy=%b, required 000",
                 c, {m0_rvalid[1], m1_rvalid[1], busy[1]});
      end
      step();
    end
    drive_m0(1'b1, 32'h400, 32'hA5A5_0001, 4'b1000);
    drive_m1(1'b1, 32'h500, 32'h5A5A_0002, 4'b0001);
    wexp_q.push_back({32'h400, 4'b1000, 32'hA5A5_0001});
    @(negedge clk);
    n_cmp++;
    if ({m0_gnt[1], m1_gnt[1]} !== 2'b10) begin
      n_bad++;
      $display("FAIL midrst_first_conflict: gnt0/gnt1=%b%b, required 10", m0_gnt[1], m1_gnt[1]);
    end
    step();
    drive_idle();
    @(negedge clk);
    check_drained("midrst");
  endtask

  task automatic test_lat1_read();
    do_reset(0);
    step();
    drive_m1(1'b0, 32'h30, 32'hFFFF_FFFF, 4'b1111);
    exp_q.push_back({1'b1, mem_fn(32'h30)});
    @(negedge clk);
    n_cmp++;
    if ({m1_gnt[0], mem_req[0], mem_we[0], mem_be[0]} !== {3'b110, 4'b0000}) begin
      n_bad++;
      $display("FAIL lat1_grant: gnt/req/we/be=%b, required 1100000",
               {m1_gnt[0], mem_req[0], mem_we[0], mem_be[0]});
    end
    step();
    drive_idle();
    for (int c = 1; c <= 3; c++) begin
      logic [2:0] exp_v;
      @(negedge clk);
      exp_v = {(c == 1), 1'b0, (c == 2)};
      n_cmp++;
      if ({busy[0], m0_rvalid[0], m1_rvalid[0]} !== exp_v) begin
        n_bad++;
        $display("FAIL lat1_T+%0d: busy/rv0/rv1=%b, required %b",
                 c, {busy[0], m0_rvalid[0], m1_rvalid[0]}, exp_v);
      end
      step();
    end
    check_drained("lat1");
  endtask

  // Random mixed traffic on the latency-2 instance; expectations come from a
  // tiny reference model of grant order and read timing.
  task automatic test_random_mix();
    logic last;
    int   wait_left;
    do_reset(1);
    last = 1'b1;
    wait_left = 0;
    step();
    for (int c = 0; c < 60; c++) begin
      logic r0, r1, w0, w1, win, any;
      logic [31:0] a0, a1, d0, d1;
      r0 = ($urandom_range(0, 2) != 0); r1 = ($urandom_range(0, 2) != 0);
      w0 = $urandom_range(0, 1) == 1;  w1 = $urandom_range(0, 1) == 1;
      a0 = 32'($urandom_range(0, 255)) << 2; a1 = 32'($urandom_range(0, 255)) << 2;
      d0 = $urandom(); d1 = $urandom();
      drive_idle();
      if (r0) drive_m0(w0, a0, d0, 4'b1111);
      if (r1) drive_m1(w1, a1, d1, 4'b1100);
      any = (wait_left == 0) && (r0 || r1);
      win = (r0 && r1) ? ~last : r1;
      if (any) begin
        last = win;
        if (win ? w1 : w0) begin
          if (win) wexp_q.push_back({a1, 4'b1100, d1});
          else     wexp_q.push_back({a0, 4'b1111, d0});
        end else begin
          exp_q.push_back({win, mem_fn(win ? a1 : a0)});
          wait_left = 2;
        end
      end else if (wait_left > 0) begin
        wait_left--;
      end
      @(negedge clk);
      n_cmp++;
      if ({m0_gnt[1], m1_gnt[1]} !== {any && !win, any && win}) begin
        n_bad++;
        $display("FAIL random_grant_c%0d: gnt0/gnt1=%b%b, required %b%b",
                 c, m0_gnt[1], m1_gnt[1], any && !win, any && win);
      end
      step();
    end
    drive_idle();
    for (int c = 0; c < 4; c++) step();
    check_drained("random");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_stall_wait();
    test_reset_mid_read();
    test_lat1_read();
    test_random_mix();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
